// File: rtl/pc_seq.sv
// Program-counter sequencer: jump, signed branch, stall, call/return stack and sticky halt.
// Optional PC_SEQ_RETIRE_CNT_EN adds a saturating 32-bit retire counter output.
module pc_seq #(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 8,
    parameter int HALT_ADDR = 63,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         init,
    input  logic                         stall,
    input  logic                         jump_en,
    input  logic                         branch_en,
    input  logic                         call_en,
    input  logic                         ret_en,
    input  logic [PC_W-1:0]              target,
    input  logic [OFF_W-1:0]             offset,
    output logic [PC_W-1:0]              PC,
    output logic                         halt,
    output logic                         ras_err,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]                  retire_cnt
`endif
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [PC_W-1:0]  HALT_PC  = PC_W'(HALT_ADDR);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]        stack [RAS_DEPTH];
    logic                   over;
    logic                   advance;
    logic                   full;
    logic                   push_en;
    logic [PC_W-1:0]        pc_inc;
    logic signed [PC_W-1:0] off_ext;
    logic [IDX_W-1:0]       top_idx;
    logic [IDX_W-1:0]       push_idx;

    always_comb begin
        over     = PC > HALT_PC;
        advance  = !halt && !over && !stall;
        full     = ras_cnt == CNT_FULL;
        push_en  = advance && !ret_en && call_en && !full;
        pc_inc   = PC + PC_W'(1);
        off_ext  = PC_W'($signed(offset));
        top_idx  = IDX_W'(ras_cnt - CNT_W'(1));
        push_idx = IDX_W'(ras_cnt);
    end

    always_ff @(posedge CLK or posedge init) begin
        if (init) begin
            PC      <= '0;
            halt    <= 1'b0;
            ras_err <= 1'b0;
            ras_cnt <= '0;
        end else if (!halt) begin
            if (over) begin
                halt <= 1'b1;
            end else if (!stall) begin
                if (ret_en) begin
                    if (ras_cnt != '0) begin
                        PC      <= stack[top_idx];
                        ras_cnt <= ras_cnt - CNT_W'(1);
                    end else begin
                        ras_err <= 1'b1;
                        PC      <= pc_inc;
                    end
                end else if (call_en) begin
                    PC <= target;
                    if (!full) ras_cnt <= ras_cnt + CNT_W'(1);
                    else       ras_err <= 1'b1;
                end else if (jump_en) begin
                    PC <= target;
                end else if (branch_en) begin
                    PC <= PC + off_ext;
                end else begin
                    PC <= pc_inc;
                end
            end
        end
    end

    // Stack storage needs no reset; ras_cnt alone defines which entries are valid.
    always_ff @(posedge CLK) begin
        if (push_en) stack[push_idx] <= pc_inc;
    end

`ifdef PC_SEQ_RETIRE_CNT_EN
    always_ff @(posedge CLK or posedge init) begin
        if (init)
            retire_cnt <= '0;
        else if (advance && retire_cnt != '1)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: queue-based reference model compared every cycle, plus directed literal checks.
// A second instance with HALT_ADDR=1023 exercises PC wrap-around without halting.
module tb_pc_seq;

    logic       CLK = 1'b0;
    logic       init;
    logic       stall, jump_en, branch_en, call_en, ret_en;
    logic [9:0] target;
    logic [7:0] offset;
    logic [9:0] PC, PC2;
    logic       halt, halt2, ras_err, ras_err2;
    logic [2:0] ras_cnt, ras_cnt2;
`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt, retire_cnt2;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    pc_seq #(.PC_W(10), .OFF_W(8), .HALT_ADDR(63), .RAS_DEPTH(4)) u_dut (
        .CLK(CLK), .init(init), .stall(stall), .jump_en(jump_en), .branch_en(branch_en),
        .call_en(call_en), .ret_en(ret_en), .target(target), .offset(offset),
        .PC(PC), .halt(halt), .ras_err(ras_err), .ras_cnt(ras_cnt)
`ifdef PC_SEQ_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    pc_seq #(.PC_W(10), .OFF_W(8), .HALT_ADDR(1023), .RAS_DEPTH(4)) u_wrap (
        .CLK(CLK), .init(init), .stall(stall), .jump_en(jump_en), .branch_en(branch_en),
        .call_en(call_en), .ret_en(ret_en), .target(target), .offset(offset),
        .PC(PC2), .halt(halt2), .ras_err(ras_err2), .ras_cnt(ras_cnt2)
`ifdef PC_SEQ_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt2)
`endif
    );

    // Reference model for u_dut (HALT_ADDR=63, depth 4, 10-bit PC)
    int          m_pc;
    bit          m_halt, m_err;
    int          m_stk[$];
    int          m_off;
    logic [31:0] m_ret;

    always @(posedge CLK or posedge init) begin
        if (init) begin
            m_pc = 0; m_halt = 0; m_err = 0; m_ret = 0;
            m_stk.delete();
        end else if (!m_halt) begin
            if (m_pc > 63) begin
                m_halt = 1;
            end else if (!stall) begin
                if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
                if (ret_en) begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_err = 1; m_pc = (m_pc + 1) % 1024; end
                end else if (call_en) begin
                    if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % 1024);
                    else m_err = 1;
                    m_pc = int'(target);
                end else if (jump_en) begin
                    m_pc = int'(target);
                end else if (branch_en) begin
                    m_off = $signed(offset);
                    m_pc = (m_pc + m_off + 1024) % 1024;
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!init) begin
            n_cmp++;
            if (int'(PC) != m_pc || halt != m_halt || ras_err != m_err ||
                int'(ras_cnt) != m_stk.size()) begin
                n_fail++;
                $display("FAIL model t=%0t: PC=%0d halt=%0b err=%0b cnt=%0d, want PC=%0d halt=%0b err=%0b cnt=%0d",
                         $time, PC, halt, ras_err, ras_cnt, m_pc, m_halt, m_err, m_stk.size());
            end
`ifdef PC_SEQ_RETIRE_CNT_EN
            n_cmp++;
            if (retire_cnt != m_ret) begin
                n_fail++;
                $display("FAIL model_retire t=%0t: got %0d want %0d", $time, retire_cnt, m_ret);
            end
`endif
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; jump_en = 0; branch_en = 0; call_en = 0; ret_en = 0;
        target = '0; offset = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        init = 1;
        #2;
        init = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        idle_inputs();
        init = 1;
        #2;
        check("reset_pc", int'(PC), 0);
        check("reset_halt", int'(halt), 0);
        check("reset_err", int'(ras_err), 0);
        check("reset_cnt", int'(ras_cnt), 0);
        tick();
        init = 0;

        // Free-run into halt
        ticks(64);
        check("run_pc64", int'(PC), 64);
        check("run_nohalt", int'(halt), 0);
        tick();
        check("halt_set", int'(halt), 1);
        check("halt_pc", int'(PC), 64);
        ticks(4);
        jump_en = 1; target = 10'd5;
        tick();
        check("halt_ignores_jump", int'(PC), 64);
        check("halt_sticky", int'(halt), 1);

        // Branches
        do_reset();
        ticks(10);
        check("pre_branch", int'(PC), 10);
        branch_en = 1; offset = 8'hFB;
        tick();
        check("branch_back", int'(PC), 5);
        offset = 8'h00;
        tick();
        check("branch_zero", int'(PC), 5);
        branch_en = 0; jump_en = 1; target = 10'd1020;
        tick();
        jump_en = 0; branch_en = 1; offset = 8'h0A;
        tick();
        check("wrap_branch", int'(PC2), 6);
        branch_en = 0; jump_en = 1; target = 10'd1023;
        tick();
        jump_en = 0;
        tick();
        check("wrap_inc", int'(PC2), 0);
        check("wrap_nohalt", int'(halt2), 0);

        // Calls and returns
        do_reset();
        ticks(7);
        call_en = 1; target = 10'd40;
        tick();
        check("call1_pc", int'(PC), 40);
        check("call1_cnt", int'(ras_cnt), 1);
        call_en = 0;
        tick();
        call_en = 1; target = 10'd50;
        tick();
        check("call2_cnt", int'(ras_cnt), 2);
        call_en = 0; ret_en = 1;
        tick();
        check("ret1_pc", int'(PC), 42);
        tick();
        check("ret2_pc", int'(PC), 8);
        check("ret2_cnt", int'(ras_cnt), 0);
        tick();
        check("under_err", int'(ras_err), 1);
        check("under_pc", int'(PC), 9);
        ret_en = 0;

        // Overflow
        do_reset();
        call_en = 1;
        for (int i = 0; i < 5; i++) begin
            target = 10'(20 + i);
            tick();
            if (i == 3) check("over_err_pre", int'(ras_err), 0);
        end
        check("over_cnt", int'(ras_cnt), 4);
        check("over_err", int'(ras_err), 1);
        check("over_pc", int'(PC), 24);
        call_en = 0; ret_en = 1;
        tick();
        check("over_ret", int'(PC), 23);
        ret_en = 0;

        // Stall and priority
        do_reset();
        ticks(3);
        stall = 1; jump_en = 1; target = 10'd30;
        tick();
        check("stall_pc", int'(PC), 3);
        stall = 0; jump_en = 0; call_en = 1; target = 10'd10;
        tick();
        ret_en = 1; call_en = 1; jump_en = 1; target = 10'd50;
        tick();
        check("prio_pop_pc", int'(PC), 4);
        check("prio_pop_cnt", int'(ras_cnt), 0);
        ret_en = 0; call_en = 0; jump_en = 1; branch_en = 1; target = 10'd33; offset = 8'd5;
        tick();
        check("prio_jump", int'(PC), 33);
        idle_inputs();

        // Asynchronous init mid-call
        do_reset();
        ret_en = 1;
        tick();
        ret_en = 0; call_en = 1; target = 10'd40;
        tick();
        check("pre_init_err", int'(ras_err), 1);
        check("pre_init_cnt", int'(ras_cnt), 1);
        #3;
        call_en = 0;
        init = 1;
        #1;
        check("async_pc", int'(PC), 0);
        check("async_cnt", int'(ras_cnt), 0);
        check("async_err", int'(ras_err), 0);
`ifdef PC_SEQ_RETIRE_CNT_EN
        check("async_retire", int'(retire_cnt), 0);
`endif
        init = 0;
        tick();
`ifdef PC_SEQ_RETIRE_CNT_EN
        check("retire1", int'(retire_cnt), 1);
        tick();
        check("retire2", int'(retire_cnt), 2);
        stall = 1;
        tick();
        check("retire_stall", int'(retire_cnt), 2);
        stall = 0;
        tick();
        check("retire3", int'(retire_cnt), 3);
`else
        ticks(3);
`endif
        check("post_init_pc", int'(PC), m_pc);

        ticks(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
